cpu_ctrl_fsm: RTL

- Machine-cycle controller for the 8-bit accumulator CPU.
- Sequences fetch, decode and execute for the 3-bit ISA: HLT=000, SKZ=001, ADD=010, ANDD=011, XORR=100, LDA=101, STO=110, JMP=111.
- Issues the one-cycle alu_ena strobe that the ALU consumes, plus the memory, IR, PC and accumulator strobes.
- Sits between the instruction register and the datapath; it is the initiator of the ALU enable/opcode interface.

---
 rtl/cpu_ctrl_if.sv | 9 +
 rtl/cpu_ctrl_fsm.sv | 66 ++++++
 2 files changed

// File: rtl/cpu_ctrl_if.sv
// cpu_ctrl_if: opcode/flag inputs and datapath strobes between the controller and the datapath
interface cpu_ctrl_if;
  logic [2:0] opcode;
  logic zero, rd, wr, load_ir, ir_sel, inc_pc, load_pc, load_acc, alu_ena, datactl_ena;
  modport master(input opcode, zero,
                 output rd, wr, load_ir, ir_sel, inc_pc, load_pc, load_acc, alu_ena, datactl_ena);
  modport slave(output opcode, zero,
                input rd, wr, load_ir, ir_sel, inc_pc, load_pc, load_acc, alu_ena, datactl_ena);
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: fetch/decode/execute sequencer for the 8-bit accumulator CPU; define CPU_CTRL_RESUME_EN to allow leaving HALT via resume
module cpu_ctrl_fsm #(
  parameter int INSN_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
`ifdef CPU_CTRL_RESUME_EN
  input  logic                  resume,
`endif
  cpu_ctrl_if.master            bus,
  output logic                  halt,
  output logic [2:0]            state,
  output logic [INSN_CNT_W-1:0] insn_cnt
);
  typedef enum logic [2:0] {S_FH, S_FL, S_DEC, S_ALU, S_MEM, S_WB, S_PC, S_HALT} state_t;
  state_t st, nxt;
  logic [2:0] op_q;
  logic zero_q, en, mem_op, sto, skz, wake, retire;
`ifdef CPU_CTRL_RESUME_EN
  assign wake = st == S_HALT && resume;
`else
  assign wake = 1'b0;
`endif
  assign retire = st == S_PC || wake;
  assign en = ena && !rst;
  assign mem_op = op_q inside {3'b010, 3'b011, 3'b100, 3'b101};
  assign sto = op_q == 3'b110;
  assign skz = op_q == 3'b001 && zero_q;
  assign state = st;
  always_comb begin
    nxt = st == S_FH  ? S_FL :
          st == S_FL  ? S_DEC :
          st == S_DEC ? (bus.opcode == 3'b000 ? S_HALT : S_ALU) :
          st == S_ALU ? S_MEM :
          st == S_MEM ? S_WB :
          st == S_WB  ? S_PC :
          st == S_PC  ? S_FH :
          (wake ? S_FH : S_HALT);
    bus.rd          = en && (st inside {S_FH, S_FL} || (st inside {S_ALU, S_MEM} && mem_op));
    bus.load_ir     = en && st inside {S_FH, S_FL};
    bus.ir_sel      = en && st == S_FL;
    bus.inc_pc      = en && (st inside {S_FH, S_FL} || (st inside {S_WB, S_PC} && skz));
    bus.load_pc     = en && st == S_PC && op_q == 3'b111;
    bus.load_acc    = en && st == S_MEM && mem_op;
    bus.alu_ena     = en && st == S_ALU;
    bus.wr          = en && st inside {S_MEM, S_WB} && sto;
    bus.datactl_ena = en && st inside {S_MEM, S_WB} && sto;
    halt            = !rst && st == S_HALT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= S_FH;
      op_q     <= '0;
      zero_q   <= 1'b0;
      insn_cnt <= '0;
    end else if (ena) begin
      st <= nxt;
      if (st == S_DEC) begin
        op_q   <= bus.opcode;
        zero_q <= bus.zero;
      end
      if (retire) insn_cnt <= insn_cnt + 1'b1;
    end
  end
endmodule
